// File: rtl/kvazaar_qsys_start_pkg.sv
// Shared definitions for the Kvazaar start controller.
// Holds the Avalon word-address map, the per-channel FSM state encoding
// (visible to software through the state register) and the default
// width of the pulse-length register.
package kvazaar_qsys_start_pkg;

  localparam int PULSE_W = 8;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_PLEN  = 2'd1;
  localparam logic [1:0] ADDR_STAT  = 2'd2;
  localparam logic [1:0] ADDR_STATE = 2'd3;

  // Software decodes these values directly, so the encoding is fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BAD   = 2'd3
  } chan_state_e;

endpackage

// File: rtl/kvazaar_qsys_start_chan.sv
// One accelerator channel of the start controller.
// Synchronises the accelerator done level, detects its rising edge, and
// runs the start-pulse / wait-for-done sequencer.
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   launch_i         one-cycle launch request from a CPU write
//   pulse_len_i      requested start high time (0 behaves as 1)
//   acc_done_i       raw done level from the accelerator
//   start_o          start pulse to the accelerator
//   busy_o           channel is not idle
//   done_set_o       one-cycle request to set the sticky done bit
//   overrun_set_o    one-cycle request to set the sticky overrun bit
//   state_o          current FSM state, for software readback
module kvazaar_qsys_start_chan
  import kvazaar_qsys_start_pkg::*;
#(
  parameter int PLEN_W = PULSE_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              launch_i,
  input  logic [PLEN_W-1:0] pulse_len_i,
  input  logic              acc_done_i,
  output logic              start_o,
  output logic              busy_o,
  output logic              done_set_o,
  output logic              overrun_set_o,
  output logic [1:0]        state_o
);

  logic              s1_q, s2_q, s3_q;
  logic              done_edge;
  chan_state_e       state_q, state_d;
  logic [PLEN_W-1:0] cnt_q, cnt_d;
  logic              early_q, early_d;

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= acc_done_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign done_edge = s2_q & ~s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      early_q <= early_d;
    end
  end

  // cnt is loaded with len-1 so that the PULSE state lasts exactly len
  // cycles. A done edge that arrives while the pulse is still running is
  // remembered in early_q so the channel can skip WAIT entirely.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    early_d    = early_q;
    done_set_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch_i) begin
          state_d = ST_PULSE;
          cnt_d   = (pulse_len_i == '0) ? '0 : pulse_len_i - 1'b1;
          early_d = 1'b0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (early_q || done_edge) begin
            state_d    = ST_IDLE;
            done_set_o = 1'b1;
            early_d    = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (done_edge) begin
            early_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (done_edge) begin
          state_d    = ST_IDLE;
          done_set_o = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start_o       = (state_q == ST_PULSE);
  assign busy_o        = (state_q != ST_IDLE);
  assign overrun_set_o = launch_i & busy_o;
  assign state_o       = state_q;

endmodule

// File: rtl/kvazaar_qsys_start_ctrl.sv
// Avalon-MM slave giving the Nios CPU per-channel start control of the
// Kvazaar accelerator, with sticky done bits fed back to the result PIO.
// Ports:
//   clk, reset_n            clock and asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM slave write/address inputs
//   readdata                registered read data, one cycle latency
//   acc_done                raw accelerator done levels
//   start                   start pulses to the accelerator
//   result_ready            sticky done bits, to the input PIO in_port
// Register map (word addresses):
//   0 CTRL  R: busy[1:0]           W: 1 launches channel n
//   1 PLEN  R/W pulse length in clk cycles
//   2 STAT  R: {overrun, done}     W1C: [1:0] done, [3:2] overrun
//   3 STATE R: {state1, state0}
// The register map is laid out for exactly two channels.
module kvazaar_qsys_start_ctrl #(
  parameter int NCH           = 2,
  parameter int PULSE_W       = 8,
  parameter int PULSE_DEFAULT = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [1:0]     address,
  input  logic           chipselect,
  input  logic           write_n,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  input  logic [NCH-1:0] acc_done,
  output logic [NCH-1:0] start,
  output logic [NCH-1:0] result_ready
);

  import kvazaar_qsys_start_pkg::*;

  logic               wr;
  logic [NCH-1:0]     launch;
  logic [NCH-1:0]     busy;
  logic [NCH-1:0]     done_set, overrun_set;
  logic [NCH-1:0]     done_clr, overrun_clr;
  logic [1:0]         chan_state [NCH];
  logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
  logic [NCH-1:0]     done_q, done_d;
  logic [NCH-1:0]     overrun_q, overrun_d;
  logic [31:0]        readdata_q, readdata_d;

  assign wr     = chipselect & ~write_n;
  assign launch = (wr && address == ADDR_CTRL) ? writedata[NCH-1:0] : '0;

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    kvazaar_qsys_start_chan #(
      .PLEN_W (PULSE_W)
    ) u_chan (
      .clk_i         (clk),
      .rst_ni        (reset_n),
      .launch_i      (launch[n]),
      .pulse_len_i   (pulse_len_q),
      .acc_done_i    (acc_done[n]),
      .start_o       (start[n]),
      .busy_o        (busy[n]),
      .done_set_o    (done_set[n]),
      .overrun_set_o (overrun_set[n]),
      .state_o       (chan_state[n])
    );
  end

  // Register writes and sticky status. A hardware set in the same cycle
  // as a software clear wins, so no completion or overrun is ever lost.
  always_comb begin
    pulse_len_d = pulse_len_q;
    done_clr    = '0;
    overrun_clr = '0;
    if (wr && address == ADDR_PLEN) begin
      pulse_len_d = writedata[PULSE_W-1:0];
    end
    if (wr && address == ADDR_STAT) begin
      done_clr    = writedata[1:0];
      overrun_clr = writedata[3:2];
    end
    done_d    = (done_q & ~done_clr) | done_set;
    overrun_d = (overrun_q & ~overrun_clr) | overrun_set;
  end

  // Read mux is evaluated every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_CTRL:  readdata_d = {30'b0, busy[1:0]};
      ADDR_PLEN:  readdata_d = {{(32-PULSE_W){1'b0}}, pulse_len_q};
      ADDR_STAT:  readdata_d = {28'b0, overrun_q[1:0], done_q[1:0]};
      ADDR_STATE: readdata_d = {28'b0, chan_state[1], chan_state[0]};
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len_q <= PULSE_W'(PULSE_DEFAULT);
      done_q      <= '0;
      overrun_q   <= '0;
      readdata_q  <= '0;
    end else begin
      pulse_len_q <= pulse_len_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign result_ready = done_q;

endmodule
